ret_pred_ctrl: RTL and testbench

RET_PRED_CTRL -- requirements
Module: ret_pred_ctrl

---
 rtl/ret_pred_ctrl_pkg.sv | 20 ++
 rtl/ret_pred_ctrl_pend.sv | 68 ++++++
 rtl/ret_pred_ctrl.sv | 177 +++++++++++++++++
 tb/tb_ret_pred_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ret_pred_ctrl_pkg.sv
// Shared decode constants and FSM encoding for the return-address predictor.
// RET_STACK_RESTORE_EN adds the RESTORE state used to rewind speculative pops.
package core_defines;

  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;
  localparam logic [4:0] REG_RA   = 5'd1;
  localparam logic [4:0] REG_T0   = 5'd5;

`ifdef RET_STACK_RESTORE_EN
  typedef enum logic [1:0] {IDLE = 2'd0, PUSH_PEND = 2'd1, RESTORE = 2'd2} ret_state_e;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, PUSH_PEND = 2'd1} ret_state_e;
`endif

  function automatic logic is_link(input logic [4:0] r);
    return (r == REG_RA) || (r == REG_T0);
  endfunction

endpackage

// File: rtl/ret_pred_ctrl_pend.sv
// ret_pend_fifo: synchronous FIFO holding decoded-but-unresolved returns.
// A write is accepted while full when a read happens in the same cycle.
module ret_pend_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33
) (
  input  logic                     cpu_clk,
  input  logic                     cpu_rstn,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             do_wr, do_rd;

  assign count   = count_q;
  assign full    = (count_q == DEPTH[PW:0]);
  assign empty   = (count_q == '0);
  assign rd_data = mem_q[rd_ptr_q];
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_wr) begin
        mem_d[wr_ptr_q] = wr_data;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (do_rd) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + (PW + 1)'(do_wr) - (PW + 1)'(do_rd);
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ret_pred_ctrl.sv
// Return-address prediction controller: classifies calls/returns in decode and
// checks predictions at execute. Optional macro: RET_STACK_RESTORE_EN.
module ret_pred_ctrl
  import core_defines::*;
#(
  parameter int PEND_DEPTH = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_rstn,
  input  logic                  dec_valid,
  input  logic [31:0]           instr_dec,
  input  logic [ADDR_WIDTH-1:0] pc_dec,
  input  logic                  stack_empty,
  input  logic [ADDR_WIDTH-1:0] ret_addr,
  input  logic                  ex_ret_valid,
  input  logic [ADDR_WIDTH-1:0] ex_ret_target,
  input  logic                  pipeline_flush,
  output logic                  ret_stack_wen,
  output logic                  ret_stack_ren,
  output logic                  ret_stack_mis_pre_rd,
  output logic                  flush_ret_stack,
  output logic                  pred_valid,
  output logic [ADDR_WIDTH-1:0] pred_addr,
  output logic                  ret_mispredict,
  output logic                  dec_stall
);
  localparam int CW = $clog2(PEND_DEPTH) + 1;
  localparam int EW = ADDR_WIDTH + 1;

  ret_state_e      state_q, state_d;
  logic [CW-1:0]   pred_cnt_q, pred_cnt_d;
  logic            ret_mispredict_q, ret_mispredict_d;
  logic            flush_ret_stack_q, flush_ret_stack_d;

  logic [6:0]      opcode;
  logic [4:0]      rd, rs1;
  logic            is_jal, is_jalr, rd_link, rs1_link;
  logic            push_cls, pop_cls, coro_cls;
  logic            accept, fifo_wr, do_pop;
  logic            fifo_rd, fifo_clr, fifo_full, fifo_empty;
  logic [EW-1:0]   fifo_wdata, fifo_head;
  logic [CW-1:0]   unused_pend_count;
  logic            head_pred, retire_pred, mis_det;
  logic [CW-1:0]   flush_n;
  logic            unused_bits;

  assign unused_bits = ^{pc_dec, instr_dec[31:20]};

  assign opcode   = instr_dec[6:0];
  assign rd       = instr_dec[11:7];
  assign rs1      = instr_dec[19:15];
  assign is_jal   = (opcode == OPC_JAL);
  assign is_jalr  = (opcode == OPC_JALR) && (instr_dec[14:12] == 3'b000);
  assign rd_link  = is_link(rd);
  assign rs1_link = is_link(rs1);

  // rd==rs1 with both linked is a plain push; differing links is a coroutine swap.
  assign push_cls = (is_jal && rd_link) || (is_jalr && rd_link && (!rs1_link || (rd == rs1)));
  assign pop_cls  = is_jalr && rs1_link && (!rd_link || (rd != rs1));
  assign coro_cls = is_jalr && rd_link && rs1_link && (rd != rs1);

  assign dec_stall = (state_q != IDLE) || (dec_valid && pop_cls && fifo_full);
  assign accept    = dec_valid && !dec_stall && !pipeline_flush;
  assign fifo_wr   = accept && pop_cls;
  assign do_pop    = fifo_wr && !stack_empty;
  assign fifo_wdata = {do_pop, pred_addr};

  assign head_pred   = fifo_head[EW-1];
  assign fifo_rd     = ex_ret_valid && !fifo_empty;
  assign retire_pred = fifo_rd && head_pred;
  assign mis_det     = retire_pred && (fifo_head[ADDR_WIDTH-1:0] != ex_ret_target);
  assign fifo_clr    = mis_det || pipeline_flush;
  // The resolving return is older than anything the flush discards.
  assign flush_n     = pred_cnt_q - CW'(retire_pred);

  ret_pend_fifo #(
    .DEPTH (PEND_DEPTH),
    .WIDTH (EW)
  ) u_pend_fifo (
    .cpu_clk  (cpu_clk),
    .cpu_rstn (cpu_rstn),
    .clr      (fifo_clr),
    .wr_en    (fifo_wr),
    .wr_data  (fifo_wdata),
    .rd_en    (fifo_rd),
    .rd_data  (fifo_head),
    .count    (unused_pend_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

`ifdef RET_STACK_RESTORE_EN
  logic          restore_go;
  logic [CW-1:0] restore_cnt_q, restore_cnt_d;

  assign restore_go = pipeline_flush && !mis_det && (flush_n != '0) && (state_q != RESTORE);

  always_comb begin
    restore_cnt_d = restore_cnt_q;
    if (restore_go)              restore_cnt_d = flush_n;
    else if (state_q == RESTORE) restore_cnt_d = restore_cnt_q - CW'(1);
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) restore_cnt_q <= '0;
    else           restore_cnt_q <= restore_cnt_d;
  end
`endif

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept && coro_cls) state_d = PUSH_PEND;
`ifdef RET_STACK_RESTORE_EN
        if (restore_go) state_d = RESTORE;
`endif
      end
      PUSH_PEND: begin
        state_d = IDLE;
`ifdef RET_STACK_RESTORE_EN
        if (restore_go) state_d = RESTORE;
`endif
      end
`ifdef RET_STACK_RESTORE_EN
      RESTORE: begin
        if (restore_cnt_q == CW'(1)) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ret_stack_ren        = do_pop;
    pred_valid           = do_pop;
    pred_addr            = do_pop ? ret_addr : '0;
    // A flush while the coroutine push is pending drops that push.
    ret_stack_wen        = (accept && push_cls) || ((state_q == PUSH_PEND) && !pipeline_flush);
`ifdef RET_STACK_RESTORE_EN
    ret_stack_mis_pre_rd = (state_q == RESTORE);
`else
    ret_stack_mis_pre_rd = 1'b0;
`endif
    ret_mispredict       = ret_mispredict_q;
    flush_ret_stack      = flush_ret_stack_q;
  end

  always_comb begin
    pred_cnt_d        = fifo_clr ? '0 : pred_cnt_q + CW'(do_pop) - CW'(retire_pred);
    ret_mispredict_d  = mis_det;
`ifdef RET_STACK_RESTORE_EN
    flush_ret_stack_d = mis_det;
`else
    flush_ret_stack_d = mis_det || (pipeline_flush && (flush_n != '0));
`endif
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      pred_cnt_q        <= '0;
      ret_mispredict_q  <= 1'b0;
      flush_ret_stack_q <= 1'b0;
    end else begin
      pred_cnt_q        <= pred_cnt_d;
      ret_mispredict_q  <= ret_mispredict_d;
      flush_ret_stack_q <= flush_ret_stack_d;
    end
  end

endmodule

// File: tb/tb_ret_pred_ctrl.sv
// Directed self-checking bench for ret_pred_ctrl (default PEND_DEPTH=4).
// Expectations follow RET_STACK_RESTORE_EN when it is defined.
module tb_ret_pred_ctrl;
  localparam int AW = 32;

  logic          cpu_clk = 1'b0;
  logic          cpu_rstn = 1'b1;
  logic          dec_valid, stack_empty, ex_ret_valid, pipeline_flush;
  logic [31:0]   instr_dec;
  logic [AW-1:0] pc_dec, ret_addr, ex_ret_target;
  logic          ret_stack_wen, ret_stack_ren, ret_stack_mis_pre_rd, flush_ret_stack;
  logic          pred_valid, ret_mispredict, dec_stall;
  logic [AW-1:0] pred_addr;

  int total = 0;
  int bad   = 0;

  always #5 cpu_clk = ~cpu_clk;

  ret_pred_ctrl #(.PEND_DEPTH(4), .ADDR_WIDTH(AW)) dut (
    .cpu_clk              (cpu_clk),
    .cpu_rstn             (cpu_rstn),
    .dec_valid            (dec_valid),
    .instr_dec            (instr_dec),
    .pc_dec               (pc_dec),
    .stack_empty          (stack_empty),
    .ret_addr             (ret_addr),
    .ex_ret_valid         (ex_ret_valid),
    .ex_ret_target        (ex_ret_target),
    .pipeline_flush       (pipeline_flush),
    .ret_stack_wen        (ret_stack_wen),
    .ret_stack_ren        (ret_stack_ren),
    .ret_stack_mis_pre_rd (ret_stack_mis_pre_rd),
    .flush_ret_stack      (flush_ret_stack),
    .pred_valid           (pred_valid),
    .pred_addr            (pred_addr),
    .ret_mispredict       (ret_mispredict),
    .dec_stall            (dec_stall)
  );

  function automatic logic [31:0] enc_jal(input logic [4:0] rd);
    return {20'h0, rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_jalr(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'h0, rs1, 3'b000, rd, 7'b1100111};
  endfunction

  task automatic step;
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic idle_inputs;
    dec_valid      = 1'b0;
    instr_dec      = '0;
    pc_dec         = '0;
    stack_empty    = 1'b1;
    ret_addr       = '0;
    ex_ret_valid   = 1'b0;
    ex_ret_target  = '0;
    pipeline_flush = 1'b0;
  endtask

  task automatic test_reset;
    idle_inputs();
    #2 cpu_rstn = 1'b0;
    #12;
    total++; if (ret_stack_wen !== 1'b0) begin bad++; $display("[TB] FAIL rst_wen got=%0b exp=0", ret_stack_wen); end
    total++; if (ret_stack_ren !== 1'b0) begin bad++; $display("[TB] FAIL rst_ren got=%0b exp=0", ret_stack_ren); end
    total++; if (ret_stack_mis_pre_rd !== 1'b0) begin bad++; $display("[TB] FAIL rst_mis_pre_rd got=%0b exp=0", ret_stack_mis_pre_rd); end
    total++; if (flush_ret_stack !== 1'b0) begin bad++; $display("[TB] FAIL rst_flush got=%0b exp=0", flush_ret_stack); end
    total++; if (pred_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_pred_valid got=%0b exp=0", pred_valid); end
    total++; if (pred_addr !== '0) begin bad++; $display("[TB] FAIL rst_pred_addr got=%0h exp=0", pred_addr); end
    total++; if (ret_mispredict !== 1'b0) begin bad++; $display("[TB] FAIL rst_mispredict got=%0b exp=0", ret_mispredict); end
    total++; if (dec_stall !== 1'b0) begin bad++; $display("[TB] FAIL rst_stall got=%0b exp=0", dec_stall); end
    step();
    cpu_rstn = 1'b1;
    step();
  endtask

  task automatic test_push;
    dec_valid = 1'b1; instr_dec = enc_jal(5'd1); pc_dec = 32'h100;
    #2;
    total++; if (ret_stack_wen !== 1'b1) begin bad++; $display("[TB] FAIL push_wen got=%0b exp=1", ret_stack_wen); end
    total++; if (ret_stack_ren !== 1'b0) begin bad++; $display("[TB] FAIL push_ren got=%0b exp=0", ret_stack_ren); end
    total++; if (dec_stall !== 1'b0) begin bad++; $display("[TB] FAIL push_stall got=%0b exp=0", dec_stall); end
    step();
    idle_inputs();
    ex_ret_valid = 1'b1; ex_ret_target = 32'hdead;
    step();
    ex_ret_valid = 1'b0;
    total++; if (ret_mispredict !== 1'b0) begin bad++; $display("[TB] FAIL push_no_fifo got=%0b exp=0", ret_mispredict); end
  endtask

  task automatic test_pop(input logic [AW-1:0] target, input logic exp_mis);
    dec_valid = 1'b1; instr_dec = enc_jal(5'd1); pc_dec = 32'h100; stack_empty = 1'b1;
    step();
    instr_dec = enc_jalr(5'd0, 5'd1); pc_dec = 32'h180; stack_empty = 1'b0; ret_addr = 32'h104;
    #2;
    total++; if (ret_stack_ren !== 1'b1) begin bad++; $display("[TB] FAIL pop_ren got=%0b exp=1", ret_stack_ren); end
    total++; if (pred_valid !== 1'b1) begin bad++; $display("[TB] FAIL pop_pred_valid got=%0b exp=1", pred_valid); end
    total++; if (pred_addr !== 32'h104) begin bad++; $display("[TB] FAIL pop_pred_addr got=%0h exp=104", pred_addr); end
    total++; if (ret_stack_wen !== 1'b0) begin bad++; $display("[TB] FAIL pop_wen got=%0b exp=0", ret_stack_wen); end
    step();
    idle_inputs();
    ex_ret_valid = 1'b1; ex_ret_target = target;
    step();
    ex_ret_valid = 1'b0;
    total++; if (ret_mispredict !== exp_mis) begin bad++; $display("[TB] FAIL resolve_mis got=%0b exp=%0b", ret_mispredict, exp_mis); end
    total++; if (flush_ret_stack !== exp_mis) begin bad++; $display("[TB] FAIL resolve_flush got=%0b exp=%0b", flush_ret_stack, exp_mis); end
    step();
    total++; if (ret_mispredict !== 1'b0) begin bad++; $display("[TB] FAIL resolve_mis_pulse got=%0b exp=0", ret_mispredict); end
    total++; if (flush_ret_stack !== 1'b0) begin bad++; $display("[TB] FAIL resolve_flush_pulse got=%0b exp=0", flush_ret_stack); end
  endtask

  task automatic test_empty_pop;
    dec_valid = 1'b1; instr_dec = enc_jalr(5'd0, 5'd5); stack_empty = 1'b1; ret_addr = 32'h444;
    #2;
    total++; if (ret_stack_ren !== 1'b0) begin bad++; $display("[TB] FAIL empty_ren got=%0b exp=0", ret_stack_ren); end
    total++; if (pred_valid !== 1'b0) begin bad++; $display("[TB] FAIL empty_pred_valid got=%0b exp=0", pred_valid); end
    total++; if (dec_stall !== 1'b0) begin bad++; $display("[TB] FAIL empty_stall got=%0b exp=0", dec_stall); end
    step();
    idle_inputs();
    ex_ret_valid = 1'b1; ex_ret_target = 32'h999;
    step();
    ex_ret_valid = 1'b0;
    total++; if (ret_mispredict !== 1'b0) begin bad++; $display("[TB] FAIL empty_unpredicted got=%0b exp=0", ret_mispredict); end
  endtask

  task automatic test_flush_restore;
    for (int i = 0; i < 3; i++) begin
      dec_valid = 1'b1; instr_dec = enc_jalr(5'd0, 5'd1); stack_empty = 1'b0; ret_addr = 32'h400 + 32'(4 * i);
      step();
    end
    idle_inputs();
    pipeline_flush = 1'b1;
    step();
    pipeline_flush = 1'b0;
`ifdef RET_STACK_RESTORE_EN
    for (int i = 0; i < 3; i++) begin
      total++; if (ret_stack_mis_pre_rd !== 1'b1) begin bad++; $display("[TB] FAIL restore_rd[%0d] got=%0b exp=1", i, ret_stack_mis_pre_rd); end
      total++; if (dec_stall !== 1'b1) begin bad++; $display("[TB] FAIL restore_stall[%0d] got=%0b exp=1", i, dec_stall); end
      step();
    end
    total++; if (ret_stack_mis_pre_rd !== 1'b0) begin bad++; $display("[TB] FAIL restore_end_rd got=%0b exp=0", ret_stack_mis_pre_rd); end
    total++; if (dec_stall !== 1'b0) begin bad++; $display("[TB] FAIL restore_end_stall got=%0b exp=0", dec_stall); end
`else
    total++; if (flush_ret_stack !== 1'b1) begin bad++; $display("[TB] FAIL flushn_pulse got=%0b exp=1", flush_ret_stack); end
    total++; if (ret_stack_mis_pre_rd !== 1'b0) begin bad++; $display("[TB] FAIL flushn_rd got=%0b exp=0", ret_stack_mis_pre_rd); end
    step();
    total++; if (flush_ret_stack !== 1'b0) begin bad++; $display("[TB] FAIL flushn_pulse_end got=%0b exp=0", flush_ret_stack); end
`endif
    pipeline_flush = 1'b1;
    step();
    pipeline_flush = 1'b0;
    total++; if (flush_ret_stack !== 1'b0) begin bad++; $display("[TB] FAIL flush0_pulse got=%0b exp=0", flush_ret_stack); end
    total++; if (ret_stack_mis_pre_rd !== 1'b0) begin bad++; $display("[TB] FAIL flush0_rd got=%0b exp=0", ret_stack_mis_pre_rd); end
  endtask

  task automatic test_coroutine;
    dec_valid = 1'b1; instr_dec = enc_jalr(5'd5, 5'd1); stack_empty = 1'b0; ret_addr = 32'h500;
    #2;
    total++; if (ret_stack_ren !== 1'b1) begin bad++; $display("[TB] FAIL coro_c0_ren got=%0b exp=1", ret_stack_ren); end
    total++; if (ret_stack_wen !== 1'b0) begin bad++; $display("[TB] FAIL coro_c0_wen got=%0b exp=0", ret_stack_wen); end
    total++; if (dec_stall !== 1'b0) begin bad++; $display("[TB] FAIL coro_c0_stall got=%0b exp=0", dec_stall); end
    step();
    dec_valid = 1'b0;
    #2;
    total++; if (ret_stack_wen !== 1'b1) begin bad++; $display("[TB] FAIL coro_c1_wen got=%0b exp=1", ret_stack_wen); end
    total++; if (ret_stack_ren !== 1'b0) begin bad++; $display("[TB] FAIL coro_c1_ren got=%0b exp=0", ret_stack_ren); end
    total++; if (dec_stall !== 1'b1) begin bad++; $display("[TB] FAIL coro_c1_stall got=%0b exp=1", dec_stall); end
    step();
    total++; if (ret_stack_wen !== 1'b0) begin bad++; $display("[TB] FAIL coro_c2_wen got=%0b exp=0", ret_stack_wen); end
    total++; if (dec_stall !== 1'b0) begin bad++; $display("[TB] FAIL coro_c2_stall got=%0b exp=0", dec_stall); end
    idle_inputs();
    ex_ret_valid = 1'b1; ex_ret_target = 32'h500;
    step();
    ex_ret_valid = 1'b0;
    total++; if (ret_mispredict !== 1'b0) begin bad++; $display("[TB] FAIL coro_resolve got=%0b exp=0", ret_mispredict); end
  endtask

  task automatic test_flush_push_pend;
    dec_valid = 1'b1; instr_dec = enc_jalr(5'd1, 5'd5); stack_empty = 1'b0; ret_addr = 32'h600;
    step();
    dec_valid = 1'b0; pipeline_flush = 1'b1;
    #2;
    total++; if (ret_stack_wen !== 1'b0) begin bad++; $display("[TB] FAIL pend_drop_wen got=%0b exp=0", ret_stack_wen); end
    step();
    pipeline_flush = 1'b0;
`ifdef RET_STACK_RESTORE_EN
    total++; if (ret_stack_mis_pre_rd !== 1'b1) begin bad++; $display("[TB] FAIL pend_restore_rd got=%0b exp=1", ret_stack_mis_pre_rd); end
    step();
    total++; if (ret_stack_mis_pre_rd !== 1'b0) begin bad++; $display("[TB] FAIL pend_restore_end got=%0b exp=0", ret_stack_mis_pre_rd); end
`else
    total++; if (flush_ret_stack !== 1'b1) begin bad++; $display("[TB] FAIL pend_flush_pulse got=%0b exp=1", flush_ret_stack); end
    step();
    total++; if (flush_ret_stack !== 1'b0) begin bad++; $display("[TB] FAIL pend_flush_end got=%0b exp=0", flush_ret_stack); end
`endif
    total++; if (ret_stack_wen !== 1'b0) begin bad++; $display("[TB] FAIL pend_late_wen got=%0b exp=0", ret_stack_wen); end
  endtask

  task automatic test_full;
    for (int i = 0; i < 4; i++) begin
      dec_valid = 1'b1; instr_dec = enc_jalr(5'd0, 5'd1); stack_empty = 1'b0; ret_addr = 32'h700 + 32'(4 * i);
      #2;
      total++; if (dec_stall !== 1'b0) begin bad++; $display("[TB] FAIL fill_stall[%0d] got=%0b exp=0", i, dec_stall); end
      step();
    end
    ret_addr = 32'h710;
    #2;
    total++; if (dec_stall !== 1'b1) begin bad++; $display("[TB] FAIL full_stall got=%0b exp=1", dec_stall); end
    total++; if (ret_stack_ren !== 1'b0) begin bad++; $display("[TB] FAIL full_ren got=%0b exp=0", ret_stack_ren); end
    step();
    ex_ret_valid = 1'b1; ex_ret_target = 32'h700;
    #2;
    total++; if (dec_stall !== 1'b1) begin bad++; $display("[TB] FAIL full_retire_stall got=%0b exp=1", dec_stall); end
    total++; if (ret_stack_ren !== 1'b0) begin bad++; $display("[TB] FAIL full_retire_ren got=%0b exp=0", ret_stack_ren); end
    step();
    ex_ret_valid = 1'b0;
    #2;
    total++; if (dec_stall !== 1'b0) begin bad++; $display("[TB] FAIL fifth_stall got=%0b exp=0", dec_stall); end
    total++; if (ret_stack_ren !== 1'b1) begin bad++; $display("[TB] FAIL fifth_ren got=%0b exp=1", ret_stack_ren); end
    total++; if (pred_addr !== 32'h710) begin bad++; $display("[TB] FAIL fifth_addr got=%0h exp=710", pred_addr); end
    step();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      ex_ret_valid = 1'b1; ex_ret_target = 32'h704 + 32'(4 * i);
      step();
      total++; if (ret_mispredict !== 1'b0) begin bad++; $display("[TB] FAIL drain_mis[%0d] got=%0b exp=0", i, ret_mispredict); end
    end
    ex_ret_target = 32'hbad;
    step();
    ex_ret_valid = 1'b0;
    total++; if (ret_mispredict !== 1'b0) begin bad++; $display("[TB] FAIL drained_empty got=%0b exp=0", ret_mispredict); end
  endtask

  task automatic test_mis_and_flush;
    for (int i = 0; i < 2; i++) begin
      dec_valid = 1'b1; instr_dec = enc_jalr(5'd0, 5'd1); stack_empty = 1'b0; ret_addr = 32'h800 + 32'(4 * i);
      step();
    end
    idle_inputs();
    ex_ret_valid = 1'b1; ex_ret_target = 32'h900; pipeline_flush = 1'b1;
    step();
    ex_ret_valid = 1'b0; pipeline_flush = 1'b0;
    total++; if (ret_mispredict !== 1'b1) begin bad++; $display("[TB] FAIL mf_mis got=%0b exp=1", ret_mispredict); end
    total++; if (flush_ret_stack !== 1'b1) begin bad++; $display("[TB] FAIL mf_flush got=%0b exp=1", flush_ret_stack); end
    total++; if (ret_stack_mis_pre_rd !== 1'b0) begin bad++; $display("[TB] FAIL mf_no_restore got=%0b exp=0", ret_stack_mis_pre_rd); end
    total++; if (dec_stall !== 1'b0) begin bad++; $display("[TB] FAIL mf_stall got=%0b exp=0", dec_stall); end
    step();
    total++; if (flush_ret_stack !== 1'b0) begin bad++; $display("[TB] FAIL mf_flush_end got=%0b exp=0", flush_ret_stack); end
  endtask

  task automatic test_reset_abort;
    dec_valid = 1'b1; instr_dec = enc_jalr(5'd5, 5'd1); stack_empty = 1'b0; ret_addr = 32'ha00;
    step();
    dec_valid = 1'b0;
    #2;
    total++; if (ret_stack_wen !== 1'b1) begin bad++; $display("[TB] FAIL abort_pre_wen got=%0b exp=1", ret_stack_wen); end
    cpu_rstn = 1'b0;
    #1;
    total++; if (ret_stack_wen !== 1'b0) begin bad++; $display("[TB] FAIL abort_wen got=%0b exp=0", ret_stack_wen); end
    total++; if (dec_stall !== 1'b0) begin bad++; $display("[TB] FAIL abort_stall got=%0b exp=0", dec_stall); end
    step();
    cpu_rstn = 1'b1;
    idle_inputs();
    step();
    ex_ret_valid = 1'b1; ex_ret_target = 32'hbad;
    step();
    ex_ret_valid = 1'b0;
    total++; if (ret_mispredict !== 1'b0) begin bad++; $display("[TB] FAIL abort_fifo_cleared got=%0b exp=0", ret_mispredict); end
  endtask

  initial begin
    test_reset();
    test_push();
    test_pop(32'h104, 1'b0);
    test_pop(32'h200, 1'b1);
    test_empty_pop();
    test_flush_restore();
    test_coroutine();
    test_flush_push_pend();
    test_full();
    test_mis_and_flush();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

endmodule
